// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port RAM macro.
// Imported by the sweep controller and the RAM top level.
package ram_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic logic addr_ok(
        input logic [31:0] addr,
        input logic [31:0] depth
    );
        return addr < depth;
    endfunction

endpackage

// File: rtl/ram_clr_sweep.sv
// Clear-sweep controller: owns the SWEEP/IDLE FSM and the sweep counter,
// and muxes sweep writes onto the RAM write port.
module ram_clr_sweep import ram_pkg::*; #(
    parameter int              WIDTH    = 16,
    parameter int              DEPTH    = 8,
    parameter int              ADDR_W   = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              init_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_add_i,
    input  logic [WIDTH-1:0]  d_in_i,
    output logic              busy_o,
    output logic              acc_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_wa_o,
    output logic [WIDTH-1:0]  mem_wd_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_ok;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SWEEP: begin
                if (init_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (init_i) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    // A sampled init in IDLE pre-empts any port access on that edge.
    assign busy_o   = (state_q == SWEEP);
    assign acc_en_o = (state_q == IDLE) && !init_i;
    assign wr_ok    = addr_ok(32'(wr_add_i), 32'(DEPTH));

    assign mem_we_o = busy_o | (acc_en_o & we_i & wr_ok);
    assign mem_wa_o = busy_o ? cnt_q : wr_add_i;
    assign mem_wd_o = busy_o ? INIT_VAL : d_in_i;

endmodule

// File: rtl/ram_dp_sync.sv
// Single-clock simple dual-port RAM with clear sweep, selectable read
// latency, read-during-write policy and out-of-range detection.
module ram_dp_sync import ram_pkg::*; #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 8,
    parameter int               ADDR_W   = $clog2(DEPTH),
    parameter int               RD_LAT   = 1,
    parameter int               RDW_MODE = RDW_OLD,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              init,
    output logic              busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_add,
    input  logic [WIDTH-1:0]  d_in,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_add,
    output logic [WIDTH-1:0]  d_out,
    output logic              d_valid,
    output logic              err
);

    logic              acc_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              wr_ok, rd_ok, rd_acc, rd_hit;
    logic [WIDTH-1:0]  rd_data;
    logic              err_d, err_q;
    logic              v1_q;
    logic [WIDTH-1:0]  d1_q;

    ram_clr_sweep #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .INIT_VAL (INIT_VAL)
    ) u_sweep (
        .clk      (clk),
        .clr_n    (clr_n),
        .init_i   (init),
        .we_i     (we),
        .wr_add_i (wr_add),
        .d_in_i   (d_in),
        .busy_o   (busy),
        .acc_en_o (acc_en),
        .mem_we_o (mem_we),
        .mem_wa_o (mem_wa),
        .mem_wd_o (mem_wd)
    );

    // Storage is deliberately not reset; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign wr_ok  = addr_ok(32'(wr_add), 32'(DEPTH));
    assign rd_ok  = addr_ok(32'(rd_add), 32'(DEPTH));
    assign rd_acc = acc_en & re;
    assign rd_hit = (RDW_MODE == RDW_NEW) && we && wr_ok
                    && (wr_add == rd_add);

    always_comb begin
        rd_data = '0;
        if (rd_ok) begin
            rd_data = rd_hit ? d_in : mem_q[rd_add];
        end
    end

    // Read and write faults on one edge merge into a single pulse.
    assign err_d = acc_en & ((we & ~wr_ok) | (re & ~rd_ok));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            v1_q  <= 1'b0;
            d1_q  <= '0;
            err_q <= 1'b0;
        end else begin
            v1_q  <= rd_acc;
            err_q <= err_d;
            if (rd_acc) begin
                d1_q <= rd_data;
            end
        end
    end

    assign err = err_q;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             v2_q;
            logic [WIDTH-1:0] d2_q;

            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        d2_q <= d1_q;
                    end
                end
            end

            assign d_valid = v2_q;
            assign d_out   = d2_q;
        end else begin : g_lat1
            assign d_valid = v1_q;
            assign d_out   = d1_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_sync.sv
// Self-checking bench: four RAM configurations driven in lockstep and
// compared against a behavioural model of the storage and read delay.
module tb_ram_dp_sync;

    localparam int N = 4;
    localparam int DEPS [N] = '{8, 8, 6, 6};
    localparam int LATS [N] = '{1, 2, 1, 2};
    localparam int RDWS [N] = '{0, 1, 0, 1};
    localparam logic [15:0] IVS [N] =
        '{16'hA5A5, 16'hA5A5, 16'h5A5A, 16'h5A5A};

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        init = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [2:0]  wr_add = '0;
    logic [2:0]  rd_add = '0;
    logic [15:0] d_in = '0;

    logic        o_busy [N];
    logic        o_val  [N];
    logic        o_err  [N];
    logic [15:0] o_dout [N];

    logic [15:0] m_mem  [N][8];
    int          m_left [N];
    logic        s_v    [N];
    logic [15:0] s_d    [N];
    logic        e_busy [N];
    logic        e_val  [N];
    logic        e_err  [N];
    logic [15:0] e_dout [N];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        ram_dp_sync #(
            .WIDTH    (16),
            .DEPTH    (DEPS[g]),
            .RD_LAT   (LATS[g]),
            .RDW_MODE (RDWS[g]),
            .INIT_VAL (IVS[g])
        ) u_dut (
            .clk     (clk),
            .clr_n   (clr_n),
            .init    (init),
            .busy    (o_busy[g]),
            .we      (we),
            .wr_add  (wr_add),
            .d_in    (d_in),
            .re      (re),
            .rd_add  (rd_add),
            .d_out   (o_dout[g]),
            .d_valid (o_val[g]),
            .err     (o_err[g])
        );
    end

    task automatic mdl_reset();
        for (int k = 0; k < N; k++) begin
            m_left[k] = DEPS[k];
            s_v[k] = 1'b0;
            s_d[k] = '0;
            e_busy[k] = 1'b1;
            e_val[k] = 1'b0;
            e_err[k] = 1'b0;
            e_dout[k] = '0;
        end
    endtask

    // One clock: the model consumes the inputs sampled at the edge,
    // then the bench returns on the falling edge to observe outputs.
    task automatic cyc();
        logic        nv;
        logic        nerr;
        logic [15:0] nd;
        @(posedge clk);
        if (clr_n) begin
            for (int k = 0; k < N; k++) begin
                nv = 1'b0;
                nerr = 1'b0;
                nd = '0;
                if (m_left[k] != 0) begin
                    if (init) m_left[k] = DEPS[k];
                    else begin
                        m_left[k]--;
                        if (m_left[k] == 0)
                            for (int a = 0; a < 8; a++) m_mem[k][a] = IVS[k];
                    end
                end else if (init) begin
                    m_left[k] = DEPS[k];
                end else begin
                    if (re) begin
                        nv = 1'b1;
                        if (int'(rd_add) < DEPS[k])
                            nd = (RDWS[k] == 1 && we && wr_add == rd_add)
                                 ? d_in : m_mem[k][rd_add];
                    end
                    nerr = (we && int'(wr_add) >= DEPS[k])
                        || (re && int'(rd_add) >= DEPS[k]);
                    if (we && int'(wr_add) < DEPS[k]) m_mem[k][wr_add] = d_in;
                end
                if (LATS[k] == 1) begin
                    e_val[k] = nv;
                    if (nv) e_dout[k] = nd;
                end else begin
                    e_val[k] = s_v[k];
                    if (s_v[k]) e_dout[k] = s_d[k];
                    s_v[k] = nv;
                    s_d[k] = nd;
                end
                e_err[k] = nerr;
                e_busy[k] = (m_left[k] != 0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bcnt [N];
        clr_n = 1'b0;
        #2;
        mdl_reset();
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if ({o_busy[k], o_val[k], o_err[k], o_dout[k]} !== {3'b100, 16'h0}) begin
                n_fail++;
                $display("FAIL reset_vals dut%0d got b%0b v%0b e%0b d%h want b1 v0 e0 d0000",
                         k, o_busy[k], o_val[k], o_err[k], o_dout[k]);
            end
            bcnt[k] = 0;
        end
        cyc();
        cyc();
        clr_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < N; k++) if (o_busy[k]) bcnt[k]++;
            cyc();
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if ({o_busy[k], o_val[k], o_err[k], o_dout[k]} !==
                    {e_busy[k], e_val[k], e_err[k], e_dout[k]}) begin
                    n_fail++;
                    $display("FAIL reset_sweep dut%0d got b%0b v%0b d%h want b%0b v%0b d%h",
                             k, o_busy[k], o_val[k], o_dout[k], e_busy[k], e_val[k], e_dout[k]);
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (bcnt[k] != DEPS[k]) begin
                n_fail++;
                $display("FAIL busy_len dut%0d got %0d edges want %0d", k, bcnt[k], DEPS[k]);
            end
        end
    endtask

    task automatic test_sweep_values();
        for (int a = 0; a < 10; a++) begin
            re = (a < 8);
            rd_add = 3'(a);
            cyc();
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if ({o_val[k], o_err[k], o_dout[k]} !== {e_val[k], e_err[k], e_dout[k]}) begin
                    n_fail++;
                    $display("FAIL sweep_vals dut%0d a%0d got v%0b e%0b d%h want v%0b e%0b d%h",
                             k, a, o_val[k], o_err[k], o_dout[k], e_val[k], e_err[k], e_dout[k]);
                end
                if (LATS[k] == 1 && a < 8) begin
                    n_chk++;
                    if (o_dout[k] !== ((a < DEPS[k]) ? IVS[k] : 16'h0)) begin
                        n_fail++;
                        $display("FAIL init_word dut%0d a%0d got %h", k, a, o_dout[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_wr_rd();
        we = 1'b1;
        wr_add = 3'd3;
        d_in = 16'h1234;
        cyc();
        we = 1'b0;
        re = 1'b1;
        rd_add = 3'd3;
        cyc();
        re = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if ({o_val[k], o_dout[k]} !== {e_val[k], e_dout[k]}) begin
                    n_fail++;
                    $display("FAIL wr_rd dut%0d c%0d got v%0b d%h want v%0b d%h",
                             k, c, o_val[k], o_dout[k], e_val[k], e_dout[k]);
                end
                if (LATS[k] == c) begin
                    n_chk++;
                    if (o_val[k] !== 1'b1 || o_dout[k] !== 16'h1234) begin
                        n_fail++;
                        $display("FAIL wr_rd_lat dut%0d got v%0b d%h want v1 d1234",
                                 k, o_val[k], o_dout[k]);
                    end
                end
            end
            cyc();
        end
    endtask

    task automatic test_rdw();
        we = 1'b1;
        wr_add = 3'd5;
        d_in = 16'h0001;
        cyc();
        d_in = 16'hBEEF;
        re = 1'b1;
        rd_add = 3'd5;
        cyc();
        we = 1'b0;
        re = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if ({o_val[k], o_dout[k]} !== {e_val[k], e_dout[k]}) begin
                    n_fail++;
                    $display("FAIL rdw dut%0d c%0d got v%0b d%h want v%0b d%h",
                             k, c, o_val[k], o_dout[k], e_val[k], e_dout[k]);
                end
                if (LATS[k] == c) begin
                    n_chk++;
                    if (o_dout[k] !== (RDWS[k] == 1 ? 16'hBEEF : 16'h0001)) begin
                        n_fail++;
                        $display("FAIL rdw_policy dut%0d got %h", k, o_dout[k]);
                    end
                end
            end
            cyc();
        end
    endtask

    task automatic test_oor();
        logic [2:0] wa [3] = '{3'd7, 3'd6, 3'd0};
        logic [2:0] ra [3] = '{3'd0, 3'd7, 3'd7};
        logic       ww [3] = '{1'b1, 1'b1, 1'b0};
        logic       rr [3] = '{1'b0, 1'b1, 1'b1};
        for (int s = 0; s < 11; s++) begin
            if (s < 3) begin
                we = ww[s];
                wr_add = wa[s];
                re = rr[s];
                rd_add = ra[s];
                d_in = 16'hDEAD;
            end else begin
                we = 1'b0;
                re = (s < 11);
                rd_add = 3'(s - 3);
            end
            cyc();
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if ({o_val[k], o_err[k], o_dout[k]} !== {e_val[k], e_err[k], e_dout[k]}) begin
                    n_fail++;
                    $display("FAIL oor dut%0d s%0d got v%0b e%0b d%h want v%0b e%0b d%h",
                             k, s, o_val[k], o_err[k], o_dout[k], e_val[k], e_err[k], e_dout[k]);
                end
                if (s < 2) begin
                    n_chk++;
                    if (o_err[k] !== (DEPS[k] == 6)) begin
                        n_fail++;
                        $display("FAIL oor_err dut%0d s%0d got %0b", k, s, o_err[k]);
                    end
                end
            end
        end
        re = 1'b0;
        cyc();
    endtask

    task automatic test_init_busy();
        int bcnt [N];
        for (int k = 0; k < N; k++) bcnt[k] = 0;
        init = 1'b1;
        cyc();
        init = 1'b0;
        for (int i = 0; i < 16; i++) begin
            init = (i == 2);
            we = (i < 9);
            re = (i < 9);
            wr_add = 3'($urandom_range(0, 5));
            rd_add = 3'($urandom_range(0, 5));
            d_in = 16'($urandom);
            for (int k = 0; k < N; k++) if (o_busy[k]) bcnt[k]++;
            cyc();
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if ({o_busy[k], o_val[k], o_err[k], o_dout[k]} !==
                    {e_busy[k], e_val[k], e_err[k], e_dout[k]}) begin
                    n_fail++;
                    $display("FAIL init_busy dut%0d i%0d got b%0b v%0b d%h want b%0b v%0b d%h",
                             k, i, o_busy[k], o_val[k], o_dout[k], e_busy[k], e_val[k], e_dout[k]);
                end
            end
        end
        init = 1'b0;
        we = 1'b0;
        re = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_chk++;
            if (bcnt[k] != DEPS[k] + 3) begin
                n_fail++;
                $display("FAIL init_len dut%0d got %0d edges want %0d", k, bcnt[k], DEPS[k] + 3);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom);
            re = 1'($urandom);
            wr_add = 3'($urandom);
            rd_add = 3'($urandom);
            d_in = 16'($urandom);
            init = ($urandom_range(0, 60) == 0);
            cyc();
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if ({o_busy[k], o_val[k], o_err[k], o_dout[k]} !==
                    {e_busy[k], e_val[k], e_err[k], e_dout[k]}) begin
                    n_fail++;
                    $display("FAIL random dut%0d i%0d got b%0b v%0b e%0b d%h want b%0b v%0b e%0b d%h",
                             k, i, o_busy[k], o_val[k], o_err[k], o_dout[k],
                             e_busy[k], e_val[k], e_err[k], e_dout[k]);
                end
            end
        end
        init = 1'b0;
        we = 1'b0;
        re = 1'b0;
        for (int i = 0; i < 12; i++) cyc();
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 2; p++) begin
            if (p == 0) begin
                init = 1'b1;
                cyc();
                init = 1'b0;
                cyc();
                cyc();
            end else begin
                re = 1'b1;
                rd_add = 3'd2;
                cyc();
                re = 1'b0;
            end
            #1 clr_n = 1'b0;
            #1;
            mdl_reset();
            for (int k = 0; k < N; k++) begin
                n_chk++;
                if ({o_busy[k], o_val[k], o_err[k], o_dout[k]} !== {3'b100, 16'h0}) begin
                    n_fail++;
                    $display("FAIL mid_reset dut%0d p%0d got b%0b v%0b e%0b d%h",
                             k, p, o_busy[k], o_val[k], o_err[k], o_dout[k]);
                end
            end
            cyc();
            clr_n = 1'b1;
            for (int i = 0; i < 10; i++) begin
                re = (i == 9);
                rd_add = 3'd1;
                cyc();
                for (int k = 0; k < N; k++) begin
                    n_chk++;
                    if ({o_busy[k], o_val[k], o_err[k], o_dout[k]} !==
                        {e_busy[k], e_val[k], e_err[k], e_dout[k]}) begin
                        n_fail++;
                        $display("FAIL mid_sweep dut%0d p%0d i%0d got b%0b v%0b d%h want b%0b v%0b d%h",
                                 k, p, i, o_busy[k], o_val[k], o_dout[k],
                                 e_busy[k], e_val[k], e_dout[k]);
                    end
                end
            end
            re = 1'b0;
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_sweep_values();
        test_wr_rd();
        test_rdw();
        test_oor();
        test_init_busy();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_dp_sync.md
# ram_dp_sync

Parametrised single-clock simple dual-port RAM: one write port, one read port, configurable width and depth. It is the next generation of the team's fixed 16x8 RAM. It adds a hardware clear sweep that initialises every word after reset or on request, a selectable read latency, a selectable read-during-write policy, and out-of-range address detection. It serves as the generic storage macro for FIFOs and buffers throughout the design.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (1..64)
- DEPTH, 8, number of words (2..1024, power of two not required)
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden
- RD_LAT, 1, read latency in clock edges (1 or 2)
- RDW_MODE, 0, same-address read-during-write policy (0 = old data, 1 = new data)
- INIT_VAL, 0, WIDTH-bit value written by the clear sweep

Ports:
- clk, in, 1, single clock for all logic
- clr_n, in, 1, reset; asynchronous, active-low
- init, in, 1, one-cycle pulse that requests a clear sweep
- busy, out, 1, high while a sweep is in progress or pending
- we, in, 1, write enable
- wr_add, in, ADDR_W, write address
- d_in, in, WIDTH, write data
- re, in, 1, read enable
- rd_add, in, ADDR_W, read address
- d_out, out, WIDTH, read data
- d_valid, out, 1, d_out carries a completed read
- err, out, 1, one-cycle pulse on an out-of-range access

## Operation
- FSM states: SWEEP, IDLE. The FSM resets into SWEEP with sweep counter cnt = 0.
- SWEEP: each edge writes mem[cnt] = INIT_VAL and increments cnt. On the edge that writes DEPTH-1, the FSM moves to IDLE and cnt returns to 0.
- IDLE: a sampled init moves the FSM to SWEEP. Otherwise port accesses are served.
- init sampled while already in SWEEP restarts the sweep from cnt = 0.
- busy = (state == SWEEP). Any we/re sampled while busy is ignored: no write, no d_valid, no err.
- Write: with we=1 in IDLE and wr_add < DEPTH, mem[wr_add] = d_in at the edge.
- Read: with re=1 in IDLE and rd_add < DEPTH, mem[rd_add] is returned after RD_LAT edges with d_valid=1.
- Read-during-write to the same address on the same edge:
  - RDW_MODE 0 returns the pre-write word.
  - RDW_MODE 1 returns d_in.
- Write and read to different addresses on the same edge are independent.
- Out-of-range address (>= DEPTH, only possible for non-power-of-two DEPTH):
  - A write is dropped.
  - A read returns d_out = 0 with d_valid = 1 on the normal latency.
  - err pulses for one cycle, aligned with the access edge + 1.
  - An out-of-range read and an out-of-range write on the same edge produce a single err pulse.
- Reads already in the output pipeline when init is sampled complete normally.
- Memory contents are not touched by clr_n itself. Initialisation happens only through the sweep that follows reset.

## Timing
- Output values while clr_n = 0:
  - busy = 1
  - d_valid = 0
  - d_out = 0
  - err = 0
- After clr_n rises, busy stays high for exactly DEPTH rising edges, then falls. The first accepted access is on the next edge.
- init sampled at edge N: busy = 1 from after edge N until after edge N+DEPTH.
- RD_LAT = 1: re sampled at edge N gives d_out/d_valid after edge N, valid during cycle N+1.
- RD_LAT = 2: an additional output register, so results are valid during cycle N+2.
- d_valid is a one-cycle pulse per accepted read. Back-to-back reads give continuous d_valid.
- d_out holds its last value when d_valid = 0.
- clr_n asserted mid-sweep or mid-read:
  - The FSM, cnt and the pipeline clear immediately.
  - The sweep restarts from 0 after release.
  - In-flight reads are lost; no d_valid.

## Structure
- Package ram_pkg holds:
  - the state typedef (SWEEP, IDLE)
  - constants RDW_OLD = 0 and RDW_NEW = 1
  - a range-check function addr_ok(addr, depth)
- Sub-module ram_clr_sweep contains the FSM, cnt, busy and the sweep write-port mux. The top level contains the array, the read pipeline and the err logic.

## Test plan
- Reset release, WIDTH=16, DEPTH=8, INIT_VAL=16'hA5A5 → busy high for 8 edges; reads of addresses 0..7 then return 16'hA5A5 with d_valid after RD_LAT edges.
- Write 0x1234 to address 3, read address 3 on the next cycle with RD_LAT=1 → d_out=0x1234 and d_valid one cycle after re. Repeat with RD_LAT=2 → data arrives one cycle later.
- Same-edge write 0xBEEF and read at address 5 (old word 0x0001) → RDW_MODE 0 returns 0x0001; RDW_MODE 1 returns 0xBEEF.
- DEPTH=6: write to address 7, then read address 7 → write dropped, d_out=0, d_valid=1, err pulses on each access; addresses 0..5 are unchanged.
- init pulse in IDLE, then init again 3 cycles later → busy lasts 3+DEPTH edges in total; we/re during busy produce no write and no d_valid.
- clr_n asserted mid-sweep with a read in flight → outputs take their reset values immediately; a full DEPTH-cycle sweep follows release; no stale d_valid.
